// File: rtl/axi_lite_reg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_lite_reg_if
// Description : AXI4-Lite slave front end for the accelerator register space.
//               Reads drive a registered address into the status register
//               block and capture its combinational read data one cycle
//               later. Writes issue a single-cycle strobe to the control
//               register block. Word-unaligned accesses get SLVERR.
// Ports       : clk, rst_n (synchronous, active-low)
//               s_axi_aw*/w*/b*  - AXI4-Lite write address/data/response
//               s_axi_ar*/r*     - AXI4-Lite read address/data
//               reg_rd_addr/reg_rd_data            - status block read port
//               reg_wr_en/addr/data/strb           - control block write port
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ADDR_WIDTH-1:0]   reg_rd_addr,
    input  logic [DATA_WIDTH-1:0]   reg_rd_data,
    output logic                    reg_wr_en,
    output logic [ADDR_WIDTH-1:0]   reg_wr_addr,
    output logic [DATA_WIDTH-1:0]   reg_wr_data,
    output logic [DATA_WIDTH/8-1:0] reg_wr_strb
);

    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_CAPT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t               rd_state_q;
    logic                    arready_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= C_RESP_OKAY;
            rd_addr_q  <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    // arready is always high here, so arvalid alone is the handshake
                    if (s_axi_arvalid) begin
                        rd_addr_q  <= s_axi_araddr;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_CAPT;
                    end
                end
                R_CAPT: begin
                    // reg_rd_addr has been stable for a full cycle; sample the block
                    rvalid_q   <= 1'b1;
                    rd_state_q <= R_RESP;
                    if (rd_addr_q[1:0] != 2'b00) begin
                        rdata_q <= '0;
                        rresp_q <= C_RESP_SLVERR;
                    end else begin
                        rdata_q <= reg_rd_data;
                        rresp_q <= C_RESP_OKAY;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_q   <= 1'b0;
                    arready_q  <= 1'b1;
                    rd_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t               wr_state_q;
    logic                    awready_q;
    logic                    wready_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [DATA_WIDTH/8-1:0] wr_strb_q;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_have;
    logic w_w_have;
    logic w_wr_aligned;

    assign w_aw_hs   = s_axi_awvalid && awready_q;
    assign w_w_hs    = s_axi_wvalid  && wready_q;
    // A channel counts as "held" once its ready has dropped, or if it
    // handshakes on this very edge.
    assign w_aw_have = w_aw_hs || !awready_q;
    assign w_w_have  = w_w_hs  || !wready_q;
    // Alignment must look at the incoming address when AW completes the pair.
    assign w_wr_aligned = w_aw_hs ? (s_axi_awaddr[1:0] == 2'b00)
                                  : (wr_addr_q[1:0]    == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= C_RESP_OKAY;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        wr_addr_q <= s_axi_awaddr;
                        awready_q <= 1'b0;
                    end
                    if (w_w_hs) begin
                        wr_data_q <= s_axi_wdata;
                        wr_strb_q <= s_axi_wstrb;
                        wready_q  <= 1'b0;
                    end
                    if (w_aw_have && w_w_have) begin
                        wr_en_q    <= w_wr_aligned;
                        wr_state_q <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    wr_en_q    <= 1'b0;
                    bvalid_q   <= 1'b1;
                    bresp_q    <= (wr_addr_q[1:0] == 2'b00) ? C_RESP_OKAY : C_RESP_SLVERR;
                    wr_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: begin
                    wr_en_q    <= 1'b0;
                    bvalid_q   <= 1'b0;
                    awready_q  <= 1'b1;
                    wready_q   <= 1'b1;
                    wr_state_q <= W_IDLE;
                end
            endcase
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign reg_rd_addr   = rd_addr_q;

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign reg_wr_en     = wr_en_q;
    assign reg_wr_addr   = wr_addr_q;
    assign reg_wr_data   = wr_data_q;
    assign reg_wr_strb   = wr_strb_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_reg_if
// Description : Self-checking bench for axi_lite_reg_if. A behavioural status
//               block answers reads; a monitor logs write strobes. Directed
//               scenarios plus randomized concurrent read/write traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_if;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [11:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [11:0] reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        reg_wr_en;
    logic [11:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // write-strobe monitor
    int          pulse_cnt = 0;
    int          pulse_cyc = 0;
    logic [11:0] mon_addr = '0;
    logic [31:0] mon_data = '0;
    logic [3:0]  mon_strb = '0;

    axi_lite_reg_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Status block: 0x010 is a constant, 0x014 is a free-running counter,
    // everything else returns a recognisable address-derived pattern.
    function automatic logic [31:0] status_val(input logic [11:0] a, input int c);
        if (a == 12'h010)      return 32'h0000_0002;
        else if (a == 12'h014) return 32'(c);
        else                   return {16'hC0DE, 4'h0, a};
    endfunction

    assign reg_rd_data = status_val(reg_rd_addr, cyc);

    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_cyc <= cyc;
            mon_addr  <= reg_wr_addr;
            mon_data  <= reg_wr_data;
            mon_strb  <= reg_wr_strb;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read; hold rready low for 'hold' cycles once rvalid appears.
    task automatic do_read(input logic [11:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] r,
                           output int lat, output int rvc, output logic ar_after,
                           output bit unstable, output bit ok);
        bit hs;
        int hs_cyc;
        ok = 0; unstable = 0; d = '0; r = '0; lat = -1; rvc = 0; ar_after = 1'bx;
        araddr = a; arvalid = 1'b1; rready = 1'b0; hs = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = (arready === 1'b1);
            tick();
        end
        arvalid = 1'b0;
        if (!hs) return;
        hs_cyc = cyc;
        ar_after = arready;
        for (int i = 0; i < 20 && rvalid !== 1'b1; i++) tick();
        if (rvalid !== 1'b1) return;
        rvc = cyc; lat = rvc - hs_cyc; d = rdata; r = rresp;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rvalid !== 1'b1 || rdata !== d || rresp !== r || arready !== 1'b0) unstable = 1;
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        ok = 1;
    endtask

    // Issue one write with independent AW / W start delays.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd,
                            output logic [1:0] r, output int bvc, output bit ok);
        bit aw_done, w_done, aw_hs, w_hs;
        aw_done = 0; w_done = 0; ok = 0; r = '0; bvc = 0;
        awaddr = a; wdata = d; wstrb = s;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            awvalid = !aw_done && (c >= awd);
            wvalid  = !w_done  && (c >= wd);
            aw_hs = awvalid && (awready === 1'b1);
            w_hs  = wvalid  && (wready  === 1'b1);
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) return;
        for (int c = 0; c < 20 && bvalid !== 1'b1; c++) tick();
        if (bvalid !== 1'b1) return;
        bvc = cyc; r = bresp;
        for (int c = 0; c < bd; c++) tick();
        bready = 1'b1;
        tick();
        bready = 1'b0;
        ok = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if ({arready, awready, wready} !== 3'b111) begin bad++; $display("FAIL reset_readies: got %b expected 111", {arready, awready, wready}); end
        total++; if ({rvalid, bvalid, reg_wr_en} !== 3'b000) begin bad++; $display("FAIL reset_valids: got %b expected 000", {rvalid, bvalid, reg_wr_en}); end
        total++; if ({rdata, rresp, bresp} !== 36'h0) begin bad++; $display("FAIL reset_resp_data: got %h expected 0", {rdata, rresp, bresp}); end
        total++; if ({reg_rd_addr, reg_wr_addr, reg_wr_data, reg_wr_strb} !== 60'h0) begin bad++; $display("FAIL reset_regport: got %h expected 0", {reg_rd_addr, reg_wr_addr, reg_wr_data, reg_wr_strb}); end
        rst_n = 1'b1;
        tick();
        total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin bad++; $display("FAIL post_reset_idle: got %b expected 11100", {arready, awready, wready, rvalid, bvalid}); end
    endtask

    task automatic test_status_read();
        logic [31:0] d; logic [1:0] r; int lat, rvc; logic ara; bit un, ok;
        do_read(12'h010, 0, d, r, lat, rvc, ara, un, ok);
        total++; if (!ok) begin bad++; $display("FAIL status_read_timeout: got incomplete expected complete"); end
        total++; if (ara !== 1'b0) begin bad++; $display("FAIL status_read_arready_drop: got %b expected 0", ara); end
        total++; if (lat != 1) begin bad++; $display("FAIL status_read_latency: got %0d expected 1", lat); end
        total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL status_read_data: got %h expected 00000002", d); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL status_read_resp: got %b expected 00", r); end
        total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL status_read_return_idle: got %b expected 01", {rvalid, arready}); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [1:0] r; int lat, rvc; logic ara; bit un, ok;
        do_read(12'h014, 5, d, r, lat, rvc, ara, un, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout: got incomplete expected complete"); end
        total++; if (un) begin bad++; $display("FAIL bp_hold_stable: got changed expected held"); end
        total++; if (d !== status_val(12'h014, rvc - 1)) begin bad++; $display("FAIL bp_captured_value: got %h expected %h", d, status_val(12'h014, rvc - 1)); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL bp_resp: got %b expected 00", r); end
    endtask

    task automatic test_write_order();
        logic [1:0] r; int bvc, p0; bit ok;
        p0 = pulse_cnt;
        do_write(12'h000, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, r, bvc, ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_order_timeout: got incomplete expected complete"); end
        total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL wr_order_pulses: got %0d expected 1", pulse_cnt - p0); end
        total++; if ({mon_addr, mon_data, mon_strb} !== {12'h000, 32'hDEAD_BEEF, 4'hF}) begin bad++; $display("FAIL wr_order_fields: got %h/%h/%h expected 000/deadbeef/f", mon_addr, mon_data, mon_strb); end
        total++; if (bvc != pulse_cyc + 1) begin bad++; $display("FAIL wr_order_bvalid_timing: got cycle %0d expected %0d", bvc, pulse_cyc + 1); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL wr_order_resp: got %b expected 00", r); end
    endtask

    task automatic test_unaligned();
        logic [31:0] d; logic [1:0] r, br; int lat, rvc, bvc, p0; logic ara; bit un, ok, wok;
        do_read(12'h012, 0, d, r, lat, rvc, ara, un, ok);
        total++; if (!ok || r !== 2'b10) begin bad++; $display("FAIL unaligned_read_resp: got %b expected 10", r); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unaligned_read_data: got %h expected 0", d); end
        p0 = pulse_cnt;
        do_write(12'h006, 32'h1234_5678, 4'hF, 0, 0, 0, br, bvc, wok);
        total++; if (pulse_cnt - p0 != 0) begin bad++; $display("FAIL unaligned_write_pulses: got %0d expected 0", pulse_cnt - p0); end
        total++; if (!wok || br !== 2'b10) begin bad++; $display("FAIL unaligned_write_resp: got %b expected 10", br); end
        // zero strobes still produce a strobe and OKAY
        p0 = pulse_cnt;
        do_write(12'h008, 32'h0BAD_F00D, 4'h0, 1, 0, 0, br, bvc, wok);
        total++; if (pulse_cnt - p0 != 1 || mon_strb !== 4'h0) begin bad++; $display("FAIL zero_strb_pulse: got %0d/%h expected 1/0", pulse_cnt - p0, mon_strb); end
        total++; if (!wok || br !== 2'b00) begin bad++; $display("FAIL zero_strb_resp: got %b expected 00", br); end
    endtask

    task automatic test_concurrent();
        logic [31:0] d, wd; logic [1:0] r, br; int lat, rvc, bvc, p0; logic ara; bit un, ok, wok;
        wd = $urandom;
        p0 = pulse_cnt;
        fork
            do_read(12'h018, 0, d, r, lat, rvc, ara, un, ok);
            do_write(12'h004, wd, 4'hA, 0, 0, 0, br, bvc, wok);
        join
        total++; if (!ok || d !== status_val(12'h018, 0) || r !== 2'b00) begin bad++; $display("FAIL conc_read: got %h/%b expected %h/00", d, r, status_val(12'h018, 0)); end
        total++; if (!wok || br !== 2'b00) begin bad++; $display("FAIL conc_write_resp: got %b expected 00", br); end
        total++; if (pulse_cnt - p0 != 1 || {mon_addr, mon_data} !== {12'h004, wd}) begin bad++; $display("FAIL conc_write_pulse: got %0d %h/%h expected 1 004/%h", pulse_cnt - p0, mon_addr, mon_data, wd); end
    endtask

    task automatic test_back_to_back();
        int hs_n, beats;
        araddr = 12'h010; arvalid = 1'b1; rready = 1'b1; hs_n = 0; beats = 0;
        for (int i = 0; i < 12; i++) begin
            if (arready === 1'b1) hs_n++;
            if (rvalid === 1'b1) begin
                beats++;
                total++; if (rdata !== 32'h2) begin bad++; $display("FAIL b2b_data: got %h expected 00000002", rdata); end
            end
            tick();
        end
        arvalid = 1'b0; rready = 1'b0;
        total++; if (hs_n != 4 || beats != 4) begin bad++; $display("FAIL b2b_rate: got %0d/%0d expected 4/4", hs_n, beats); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d; logic [1:0] r; int lat, rvc; logic ara; bit un, ok;
        araddr = 12'h010; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        tick();
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL midrst_in_resp: got %b expected 1", rvalid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if ({rvalid, arready} !== 2'b01) begin bad++; $display("FAIL midrst_cleared: got %b expected 01", {rvalid, arready}); end
        do_read(12'h01C, 1, d, r, lat, rvc, ara, un, ok);
        total++; if (!ok || d !== status_val(12'h01C, 0) || r !== 2'b00 || lat != 1) begin bad++; $display("FAIL midrst_next_read: got %h/%b/%0d expected %h/00/1", d, r, lat, status_val(12'h01C, 0)); end
    endtask

    task automatic test_random();
        logic [31:0] d, wd, exp_d; logic [1:0] r, br, exp_r, exp_b; logic [11:0] ra, wa; logic [3:0] ws;
        int lat, rvc, bvc, p0, exp_p; logic ara; bit un, ok, wok;
        for (int n = 0; n < 30; n++) begin
            ra = 12'($urandom_range(0, 63) * 4);
            wa = 12'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 4) == 0) ra[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) wa[1:0] = 2'($urandom_range(1, 3));
            wd = $urandom; ws = 4'($urandom);
            p0 = pulse_cnt;
            fork
                do_read(ra, $urandom_range(0, 3), d, r, lat, rvc, ara, un, ok);
                do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br, bvc, wok);
            join
            tick();
            // reference: aligned accesses succeed, unaligned ones are SLVERR with no side effect
            exp_r = (ra[1:0] == 2'b00) ? 2'b00 : 2'b10;
            exp_d = (ra[1:0] == 2'b00) ? status_val(ra, rvc - 1) : 32'h0;
            exp_b = (wa[1:0] == 2'b00) ? 2'b00 : 2'b10;
            exp_p = (wa[1:0] == 2'b00) ? 1 : 0;
            total++; if (!ok || un || lat != 1 || d !== exp_d || r !== exp_r) begin bad++; $display("FAIL rand_read addr=%h: got %h/%b lat=%0d unstable=%0d expected %h/%b lat=1", ra, d, r, lat, un, exp_d, exp_r); end
            total++; if (!wok || br !== exp_b || pulse_cnt - p0 != exp_p) begin bad++; $display("FAIL rand_write addr=%h: got resp=%b pulses=%0d expected resp=%b pulses=%0d", wa, br, pulse_cnt - p0, exp_b, exp_p); end
            if (exp_p == 1) begin
                total++; if ({mon_addr, mon_data, mon_strb} !== {wa, wd, ws}) begin bad++; $display("FAIL rand_write_fields: got %h/%h/%h expected %h/%h/%h", mon_addr, mon_data, mon_strb, wa, wd, ws); end
            end
            total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin bad++; $display("FAIL rand_idle: got %b expected 11100", {arready, awready, wready, rvalid, bvalid}); end
        end
    endtask

    initial begin
        test_reset();
        test_status_read();
        test_backpressure();
        test_write_order();
        test_unaligned();
        test_concurrent();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
